// File: rtl/digdug_video_pkg.sv
// rtl/digdug_video_pkg.sv - RGB332 field layout, default video timing constants and pixel type
package digdug_video_pkg;

    localparam int DEF_HTOTAL  = 384;
    localparam int DEF_HACTIVE = 288;
    localparam int DEF_VACTIVE = 224;

    localparam int R_LSB = 0;
    localparam int R_MSB = 2;
    localparam int G_LSB = 3;
    localparam int G_MSB = 5;
    localparam int B_LSB = 6;
    localparam int B_MSB = 7;

    typedef logic [7:0] pixel_t;

    // Each colour component is halved on its own so no bits bleed between fields.
    function automatic pixel_t dim_pixel(input pixel_t p);
        pixel_t d;
        d = '0;
        d[R_MSB:R_LSB] = p[R_MSB:R_LSB] >> 1;
        d[G_MSB:G_LSB] = p[G_MSB:G_LSB] >> 1;
        d[B_MSB:B_LSB] = p[B_MSB:B_LSB] >> 1;
        return d;
    endfunction

endpackage

// File: rtl/digdug_linebuf.sv
// rtl/digdug_linebuf.sv - two-bank 512 x 8 line store, one write port and one registered read port
module digdug_linebuf
    import digdug_video_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] waddr,
    input  pixel_t     wdata,
    input  logic       re,
    input  logic [9:0] raddr,
    output pixel_t     rdata
);

    // Address bit 9 selects the bank; contents are deliberately not cleared.
    pixel_t mem [0:1023];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/digdug_scandbl.sv
// rtl/digdug_scandbl.sv - 15 kHz to 31 kHz line-doubling scan converter; DIGDUG_SCANLINES_EN enables dimmed second replay
module digdug_scandbl
    import digdug_video_pkg::*;
#(
    parameter int HTOTAL   = DEF_HTOTAL,
    parameter int HACTIVE  = DEF_HACTIVE,
    parameter int HS_START = 304,
    parameter int HS_LEN   = 28,
    parameter int VACTIVE  = DEF_VACTIVE,
    parameter int VS_START = 240,
    parameter int VS_LEN   = 3
)(
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       PCLK,
    input  logic [8:0] PH,
    input  logic [8:0] PV,
    input  logic [7:0] POUT,
    input  logic       SCANLN,
    output logic       O_PCLKEN,
    output logic [7:0] O_PIX,
    output logic       O_HS,
    output logic       O_VS,
    output logic       O_HB,
    output logic       O_VB
);

    localparam logic [9:0] H_TOTAL = 10'(HTOTAL);
    localparam logic [9:0] H_LAST  = 10'(HTOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(HACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(HS_START);
    localparam logic [9:0] HS_END  = 10'(HS_START + HS_LEN);
    localparam logic [9:0] V_ACT   = 10'(VACTIVE);
    localparam logic [9:0] VS_BEG  = 10'(VS_START);
    localparam logic [9:0] VS_END  = 10'(VS_START + VS_LEN);

    logic       pclk_d;
    logic       started;
    logic [1:0] div;
    logic [8:0] out_h;
    logic       out_half;
    logic       rd_bank;
    logic [8:0] vline;

    logic       istb;
    logic       line_start;
    logic       wr_en;
    logic       emit;
    logic [9:0] ph_x;
    logic [9:0] out_h_x;
    logic [9:0] vline_x;
    logic       hb_n;
    logic       hs_n;
    logic       vb_n;
    logic       vs_n;
    pixel_t     ram_q;
    pixel_t     pix_n;

    assign istb       = PCLK & ~pclk_d;
    assign line_start = istb & (PH == 9'd0);
    assign ph_x       = {1'b0, PH};
    assign wr_en      = istb & (ph_x < H_TOTAL);
    // Nothing is emitted until the first line start after reset.
    assign emit       = started & (div == 2'd3);

    assign out_h_x = {1'b0, out_h};
    assign vline_x = {1'b0, vline};
    assign hb_n    = out_h_x >= H_ACT;
    assign hs_n    = (out_h_x >= HS_BEG) && (out_h_x < HS_END);
    assign vb_n    = vline_x >= V_ACT;
    assign vs_n    = (vline_x >= VS_BEG) && (vline_x < VS_END);

    digdug_linebuf u_linebuf (
        .clk   (MCLK),
        .we    (wr_en),
        .waddr ({PV[0], PH}),
        .wdata (POUT),
        .re    (div == 2'd2),
        .raddr ({rd_bank, out_h}),
        .rdata (ram_q)
    );

`ifdef DIGDUG_SCANLINES_EN
    always_comb begin
        pix_n = ram_q;
        if (SCANLN && out_half) begin
            pix_n = dim_pixel(ram_q);
        end
        if (hb_n || vb_n) begin
            pix_n = '0;
        end
    end
`else
    logic unused_scanln;
    assign unused_scanln = SCANLN;

    always_comb begin
        pix_n = ram_q;
        if (hb_n || vb_n) begin
            pix_n = '0;
        end
    end
`endif

    always_ff @(posedge MCLK) begin
        if (!RESET) begin
            pclk_d   <= 1'b0;
            started  <= 1'b0;
            div      <= 2'd0;
            out_h    <= 9'd0;
            out_half <= 1'b0;
            rd_bank  <= 1'b0;
            vline    <= 9'd0;
            O_PCLKEN <= 1'b0;
            O_PIX    <= 8'h00;
            O_HS     <= 1'b0;
            O_VS     <= 1'b0;
            O_HB     <= 1'b0;
            O_VB     <= 1'b0;
        end else begin
            pclk_d   <= PCLK;
            O_PCLKEN <= emit;
            if (emit) begin
                O_PIX <= pix_n;
                O_HS  <= hs_n;
                O_VS  <= vs_n;
                O_HB  <= hb_n;
                O_VB  <= vb_n;
            end
            // A line start resynchronises the replay even if a wrap lands on the same cycle.
            if (line_start) begin
                started  <= 1'b1;
                div      <= 2'd0;
                out_h    <= 9'd0;
                out_half <= 1'b0;
                rd_bank  <= ~PV[0];
                vline    <= PV;
            end else begin
                div <= div + 2'd1;
                if (emit) begin
                    if (out_h_x == H_LAST) begin
                        out_h    <= 9'd0;
                        out_half <= 1'b1;
                    end else begin
                        out_h <= out_h + 9'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_digdug_scandbl.sv
// tb/tb_digdug_scandbl.sv - directed self-checking bench for the line-doubling scan converter
`timescale 1ns/1ps
module tb_digdug_scandbl;

    logic       MCLK = 1'b0;
    logic       RESET;
    logic       PCLK;
    logic [8:0] PH;
    logic [8:0] PV;
    logic [7:0] POUT;
    logic       SCANLN;
    logic       O_PCLKEN;
    logic [7:0] O_PIX;
    logic       O_HS;
    logic       O_VS;
    logic       O_HB;
    logic       O_VB;

    typedef struct {
        logic [7:0] pix;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        int         cyc;
    } strobe_t;

    strobe_t cap_q[$];
    strobe_t pre_q[$];
    strobe_t cap_s;
    int      cyc = 0;
    int      checks = 0;
    int      fails = 0;
    bit      clr_at_start = 1'b0;

`ifdef DIGDUG_SCANLINES_EN
    localparam logic [7:0] DIM_FF = 8'h5B;
`else
    localparam logic [7:0] DIM_FF = 8'hFF;
`endif

    digdug_scandbl dut (
        .MCLK     (MCLK),
        .RESET    (RESET),
        .PCLK     (PCLK),
        .PH       (PH),
        .PV       (PV),
        .POUT     (POUT),
        .SCANLN   (SCANLN),
        .O_PCLKEN (O_PCLKEN),
        .O_PIX    (O_PIX),
        .O_HS     (O_HS),
        .O_VS     (O_VS),
        .O_HB     (O_HB),
        .O_VB     (O_VB)
    );

    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) begin
        #1;
        cyc++;
        if (O_PCLKEN === 1'b1) begin
            cap_s.pix = O_PIX;
            cap_s.hs  = O_HS;
            cap_s.vs  = O_VS;
            cap_s.hb  = O_HB;
            cap_s.vb  = O_VB;
            cap_s.cyc = cyc;
            cap_q.push_back(cap_s);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [7:0] line_data(input int mode, input int p);
        logic [7:0] v;
        v = 8'(p);
        case (mode)
            0:       return v;
            1:       return ~v;
            2:       return 8'hFF;
            default: return 8'h5A;
        endcase
    endfunction

    // One core pixel: PCLK high 4 MCLK, low 4 MCLK; called and returns on a falling MCLK edge.
    task automatic pix(input logic [8:0] ph, input logic [8:0] pv, input logic [7:0] d);
        PH   = ph;
        PV   = pv;
        POUT = d;
        PCLK = 1'b1;
        @(negedge MCLK);
        if (ph == 9'd0 && clr_at_start) begin
            pre_q = cap_q;
            cap_q.delete();
        end
        repeat (3) @(negedge MCLK);
        PCLK = 1'b0;
        repeat (4) @(negedge MCLK);
    endtask

    task automatic drive_line(input logic [8:0] pv, input int n, input int mode);
        for (int p = 0; p < n; p++) begin
            pix(9'(p), pv, line_data(mode, p));
        end
    endtask

    task automatic test_reset();
        RESET  = 1'b0;
        PCLK   = 1'b0;
        PH     = 9'd0;
        PV     = 9'd240;
        POUT   = 8'hFF;
        SCANLN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge MCLK);
            PCLK = ~PCLK;
            checks++;
            if ({O_PCLKEN, O_PIX, O_HS, O_VS, O_HB, O_VB} !== 13'd0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got %h required 0", i,
                         {O_PCLKEN, O_PIX, O_HS, O_VS, O_HB, O_VB});
            end
        end
        RESET = 1'b1;
        PH    = 9'd100;
        for (int i = 0; i < 16; i++) begin
            @(negedge MCLK);
            PCLK = i[1];
            checks++;
            if ({O_PCLKEN, O_PIX, O_HS, O_VS, O_HB, O_VB} !== 13'd0) begin
                fails++;
                $display("FAIL idle_before_line_start cycle %0d: got %h required 0", i,
                         {O_PCLKEN, O_PIX, O_HS, O_VS, O_HB, O_VB});
            end
        end
        PCLK = 1'b0;
        @(negedge MCLK);
    endtask

    task automatic test_line_replay();
        int         bad_pix, bad_sync, bad_gap, h, fi;
        logic [7:0] ep, fg, fw;
        logic [3:0] es;
        int         idx [8]     = '{287, 288, 303, 304, 331, 332, 384, 671};
        logic [9:0] exp_tab [8] = '{10'h07C, 10'h001, 10'h001, 10'h003, 10'h003, 10'h001, 10'h000, 10'h07C};
        clr_at_start = 1'b0;
        drive_line(9'd10, 384, 0);
        clr_at_start = 1'b1;
        drive_line(9'd11, 384, 3);
        @(negedge MCLK);
        checks++;
        if (cap_q.size() !== 768) begin
            fails++;
            $display("FAIL replay_strobe_count: got %0d required 768", cap_q.size());
        end
        bad_pix = 0; bad_sync = 0; bad_gap = 0; fi = 0; fg = 0; fw = 0;
        for (int i = 0; i < cap_q.size() && i < 768; i++) begin
            h  = i % 384;
            ep = (h < 288) ? 8'(h) : 8'h00;
            es = {(h >= 304 && h < 332), 1'b0, (h >= 288), 1'b0};
            if (cap_q[i].pix !== ep) begin
                if (bad_pix == 0) begin fi = i; fg = cap_q[i].pix; fw = ep; end
                bad_pix++;
            end
            if ({cap_q[i].hs, cap_q[i].vs, cap_q[i].hb, cap_q[i].vb} !== es) bad_sync++;
            if (i > 0 && (cap_q[i].cyc - cap_q[i-1].cyc) !== 4) bad_gap++;
        end
        checks++;
        if (bad_pix !== 0) begin
            fails++;
            $display("FAIL replay_pix: %0d bad (required 0), first idx %0d got %h required %h", bad_pix, fi, fg, fw);
        end
        checks++;
        if (bad_sync !== 0) begin
            fails++;
            $display("FAIL replay_sync: %0d bad strobes, required 0", bad_sync);
        end
        checks++;
        if (bad_gap !== 0) begin
            fails++;
            $display("FAIL replay_strobe_spacing: %0d gaps not 4 MCLK, required 0", bad_gap);
        end
        for (int k = 0; k < 8; k++) begin
            if (cap_q.size() > idx[k]) begin
                checks++;
                if ({cap_q[idx[k]].pix, cap_q[idx[k]].hs, cap_q[idx[k]].hb} !== exp_tab[k]) begin
                    fails++;
                    $display("FAIL replay_boundary idx %0d: got %h required %h", idx[k],
                             {cap_q[idx[k]].pix, cap_q[idx[k]].hs, cap_q[idx[k]].hb}, exp_tab[k]);
                end
            end
        end
    endtask

    task automatic test_blank_sync();
        int         bad_pix, bad_sync, h;
        logic [3:0] es;
        clr_at_start = 1'b1;
        drive_line(9'd240, 384, 2);
        @(negedge MCLK);
        checks++;
        if (cap_q.size() !== 768) begin
            fails++;
            $display("FAIL blank_strobe_count: got %0d required 768", cap_q.size());
        end
        bad_pix = 0; bad_sync = 0;
        for (int i = 0; i < cap_q.size() && i < 768; i++) begin
            h  = i % 384;
            es = {(h >= 304 && h < 332), 1'b1, (h >= 288), 1'b1};
            if (cap_q[i].pix !== 8'h00) bad_pix++;
            if ({cap_q[i].hs, cap_q[i].vs, cap_q[i].hb, cap_q[i].vb} !== es) bad_sync++;
        end
        checks++;
        if (bad_pix !== 0) begin
            fails++;
            $display("FAIL vblank_pix_zero: %0d nonzero strobes, required 0", bad_pix);
        end
        checks++;
        if (bad_sync !== 0) begin
            fails++;
            $display("FAIL vblank_sync: %0d bad strobes, required 0", bad_sync);
        end
    endtask

    task automatic test_vblank_edges();
        int         pv_tab [5] = '{223, 224, 239, 242, 243};
        logic [3:0] ex_tab [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0001};
        clr_at_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_line(9'(pv_tab[k]), 3, 0);
            checks++;
            if (cap_q.size() < 1) begin
                fails++;
                $display("FAIL vedge_strobe pv %0d: got 0 strobes required >=1", pv_tab[k]);
            end else if ({cap_q[0].hs, cap_q[0].vs, cap_q[0].hb, cap_q[0].vb} !== ex_tab[k]) begin
                fails++;
                $display("FAIL vedge_sync pv %0d: got %b required %b", pv_tab[k],
                         {cap_q[0].hs, cap_q[0].vs, cap_q[0].hb, cap_q[0].vb}, ex_tab[k]);
            end
        end
    endtask

    task automatic test_resync();
        int bad_pix;
        clr_at_start = 1'b0;
        drive_line(9'd20, 384, 0);
        clr_at_start = 1'b1;
        drive_line(9'd21, 100, 1);
        drive_line(9'd21, 64, 1);
        checks++;
        if (pre_q.size() !== 200) begin
            fails++;
            $display("FAIL resync_pre_count: got %0d required 200", pre_q.size());
        end else begin
            checks++;
            if (pre_q[199].pix !== 8'hC7) begin
                fails++;
                $display("FAIL resync_last_old_pix: got %h required c7", pre_q[199].pix);
            end
        end
        checks++;
        if (cap_q.size() < 120) begin
            fails++;
            $display("FAIL resync_post_count: got %0d required >=120", cap_q.size());
        end else begin
            bad_pix = 0;
            for (int i = 0; i < 120; i++) begin
                if (cap_q[i].pix !== 8'(i) || cap_q[i].hb !== 1'b0) bad_pix++;
            end
            checks++;
            if (bad_pix !== 0) begin
                fails++;
                $display("FAIL resync_restart_pix: %0d bad, first pix got %h required 00", bad_pix, cap_q[0].pix);
            end
            if (pre_q.size() > 0) begin
                checks++;
                if ((cap_q[0].cyc - pre_q[pre_q.size()-1].cyc) !== 4) begin
                    fails++;
                    $display("FAIL resync_first_strobe_delay: got %0d required 4",
                             cap_q[0].cyc - pre_q[pre_q.size()-1].cyc);
                end
            end
        end
    endtask

    task automatic test_stall();
        int         bad_pix, bad_gap, h;
        logic [7:0] ep;
        clr_at_start = 1'b0;
        drive_line(9'd30, 384, 1);
        clr_at_start = 1'b1;
        drive_line(9'd31, 1, 2);
        repeat (4700) @(negedge MCLK);
        checks++;
        if (cap_q.size() < 1152) begin
            fails++;
            $display("FAIL stall_strobe_count: got %0d required >=1152", cap_q.size());
        end
        bad_pix = 0; bad_gap = 0;
        for (int i = 0; i < cap_q.size() && i < 1152; i++) begin
            h  = i % 384;
            ep = (h < 288) ? ~8'(h) : 8'h00;
            if (cap_q[i].pix !== ep || cap_q[i].vb !== 1'b0) bad_pix++;
            if (i > 0 && (cap_q[i].cyc - cap_q[i-1].cyc) !== 4) bad_gap++;
        end
        checks++;
        if (bad_pix !== 0) begin
            fails++;
            $display("FAIL stall_replay_pix: %0d bad strobes, required 0", bad_pix);
        end
        checks++;
        if (bad_gap !== 0) begin
            fails++;
            $display("FAIL stall_strobe_spacing: %0d gaps not 4 MCLK, required 0", bad_gap);
        end
    endtask

    task automatic test_scanlines();
        int         bad_pix, h, fi;
        logic [7:0] ep, fg, fw;
        SCANLN       = 1'b1;
        clr_at_start = 1'b0;
        drive_line(9'd40, 384, 2);
        clr_at_start = 1'b1;
        drive_line(9'd41, 384, 3);
        @(negedge MCLK);
        SCANLN = 1'b0;
        checks++;
        if (cap_q.size() !== 768) begin
            fails++;
            $display("FAIL scanln_strobe_count: got %0d required 768", cap_q.size());
        end
        bad_pix = 0; fi = 0; fg = 0; fw = 0;
        for (int i = 0; i < cap_q.size() && i < 768; i++) begin
            h  = i % 384;
            ep = (h >= 288) ? 8'h00 : ((i >= 384) ? DIM_FF : 8'hFF);
            if (cap_q[i].pix !== ep) begin
                if (bad_pix == 0) begin fi = i; fg = cap_q[i].pix; fw = ep; end
                bad_pix++;
            end
        end
        checks++;
        if (bad_pix !== 0) begin
            fails++;
            $display("FAIL scanln_pix: %0d bad, first idx %0d got %h required %h", bad_pix, fi, fg, fw);
        end
    endtask

    initial begin
        test_reset();
        test_line_replay();
        test_blank_sync();
        test_vblank_edges();
        test_resync();
        test_stall();
        test_scanlines();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
